// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared helpers for the valid/ready FIFO: pointer advance with
//               modulo-DEPTH wrap, pointer and occupancy widths, and the
//               legal-parameter limits checked at elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Legal parameter limits
    localparam int MIN_DEPTH         = 2;
    localparam int MIN_AFULL_THRESH  = 1;
    localparam int MIN_AEMPTY_THRESH = 0;

    // Width that can hold every occupancy value 0..depth
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width that can hold every pointer value 0..depth-1 (never below 1)
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Next pointer value; wraps from depth-1 to 0 for any depth, not only
    // powers of two
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic bit params_ok(input int depth, input int afull,
                                     input int aempty);
        return (depth >= MIN_DEPTH) &&
               (afull >= MIN_AFULL_THRESH) && (afull <= depth) &&
               (aempty >= MIN_AEMPTY_THRESH) && (aempty <= depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/val_rdy_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : val_rdy_fifo_ptr
// Description : Modulo-DEPTH pointer with advance, synchronous flush and
//               asynchronous active-high reset.
// Ports       : clk, rst (async, active-high), flush (sync clear, wins over
//               advance), advance (step by one), ptr (current value).
// Revision    : 1.0 - initial release
// ============================================================================
module val_rdy_fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          advance,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (flush) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= PW'(ptr_next(int'(r_ptr), DEPTH));
        end
    end

    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/val_rdy_fifo.sv
`default_nettype none
// ============================================================================
// Module      : val_rdy_fifo
// Description : Valid/ready FIFO with show-ahead output, synchronous flush,
//               occupancy count and almost-full / almost-empty flags.
//               Optional macro VAL_RDY_FIFO_BYPASS_EN adds a combinational
//               pass-through when the FIFO is empty.
// Ports       : clk, rst (async, active-high), flush,
//               in_val / in_rdy / in_msg   - enqueue side
//               out_val / out_rdy / out_msg - dequeue side
//               count, almost_full, almost_empty - status
// Revision    : 1.0 - initial release
// ============================================================================
module val_rdy_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int NBITS         = 16,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [NBITS-1:0]              in_msg,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [NBITS-1:0]              out_msg,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          almost_full,
    output logic                          almost_empty
);

    localparam int CW = count_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    generate
        if (!params_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
            $error("val_rdy_fifo: illegal parameters DEPTH=%0d AFULL_THRESH=%0d AEMPTY_THRESH=%0d",
                   DEPTH, AFULL_THRESH, AEMPTY_THRESH);
        end
    endgenerate

    logic [NBITS-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_wr_ptr;
    logic [PW-1:0]    w_rd_ptr;
    logic             w_empty;
    logic             w_push;     // message written into storage
    logic             w_pop;      // head of storage consumed

    assign w_empty = (r_count == '0);
    // Registered-only: a dequeue in the same cycle never frees a full slot
    assign in_rdy  = (r_count != CW'(DEPTH));

`ifdef VAL_RDY_FIFO_BYPASS_EN
    logic w_bypass;
    // Empty FIFO with a ready consumer: message passes straight through
    assign w_bypass = w_empty && in_val && out_rdy;
    assign w_push   = in_val && in_rdy && !w_bypass;
    assign w_pop    = !w_empty && out_rdy;
    assign out_val  = !w_empty || in_val;
    assign out_msg  = !w_empty ? r_mem[w_rd_ptr] : (in_val ? in_msg : '0);
`else
    assign w_push   = in_val && in_rdy;
    assign w_pop    = !w_empty && out_rdy;
    assign out_val  = !w_empty;
    assign out_msg  = !w_empty ? r_mem[w_rd_ptr] : '0;
`endif

    val_rdy_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .advance (w_push),
        .ptr     (w_wr_ptr)
    );

    val_rdy_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .advance (w_pop),
        .ptr     (w_rd_ptr)
    );

    // Storage is deliberately unreset; stale contents are never visible
    // because out_msg is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= in_msg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign count        = r_count;
    assign almost_full  = (r_count >= CW'(AFULL_THRESH));
    assign almost_empty = (r_count <= CW'(AEMPTY_THRESH));

endmodule
`default_nettype wire

// File: tb/tb_val_rdy_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_val_rdy_fifo
// Description : Directed self-checking bench for val_rdy_fifo (DEPTH=4 with
//               defaults, plus a DEPTH=3 instance for pointer wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_val_rdy_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DEPTH=4 instance
    logic        flush = 1'b0, in_val = 1'b0, out_rdy = 1'b0;
    logic [15:0] in_msg = '0;
    logic        in_rdy, out_val, almost_full, almost_empty;
    logic [15:0] out_msg;
    logic [2:0]  count;

    // DEPTH=3 instance
    logic        flush3 = 1'b0, in_val3 = 1'b0, out_rdy3 = 1'b0;
    logic [15:0] in_msg3 = '0;
    logic        in_rdy3, out_val3, almost_full3, almost_empty3;
    logic [15:0] out_msg3;
    logic [1:0]  count3;

    int tests = 0;
    int fails = 0;

    logic [15:0] q[$];

    always #5 clk = ~clk;

    val_rdy_fifo dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    val_rdy_fifo #(.DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .in_val(in_val3), .in_rdy(in_rdy3), .in_msg(in_msg3),
        .out_val(out_val3), .out_rdy(out_rdy3), .out_msg(out_msg3),
        .count(count3), .almost_full(almost_full3), .almost_empty(almost_empty3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_msg;

        // ---------------- reset state ----------------
        #2;
        check("rst_count", count, 0);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_val", out_val, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_aempty", almost_empty, 1);
        check("rst_afull", almost_full, 0);
        tick();
        rst = 1'b0;
        tick();

        // ---------------- fill to full ----------------
        for (int i = 1; i <= 4; i++) begin
            in_val = 1'b1; in_msg = 16'(i); out_rdy = 1'b0;
            #1;
            check("fill_in_rdy", in_rdy, 1);
            tick();
            check("fill_count", count, i);
            check("fill_afull", almost_full, (i >= 3) ? 1 : 0);
            check("fill_aempty", almost_empty, (i <= 1) ? 1 : 0);
        end
        check("full_in_rdy", in_rdy, 0);
        in_msg = 16'h0005;
        tick();
        check("fifth_count", count, 4);
        check("fifth_head", out_msg, 16'h0001);

        // ---------------- drain in order; full ignores in_val ----------------
        in_msg = 16'h0055; in_val = 1'b1; out_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_val", out_val, 1);
            check("drain_msg", out_msg, i);
            if (i == 1) check("full_deq_in_rdy", in_rdy, 0);
            tick();
            in_val = 1'b0;
            check("drain_count", count, 4 - i);
        end
        check("drained_val", out_val, 0);
        check("drained_msg", out_msg, 0);
        check("drained_aempty", almost_empty, 1);

        // ---------------- bypass / latency ----------------
        in_val = 1'b1; in_msg = 16'hABCD; out_rdy = 1'b1;
        #1;
`ifdef VAL_RDY_FIFO_BYPASS_EN
        check("byp_val_same", out_val, 1);
        check("byp_msg_same", out_msg, 16'hABCD);
        tick();
        in_val = 1'b0;
        check("byp_count", count, 0);
`else
        check("lat_val_same", out_val, 0);
        tick();
        in_val = 1'b0; out_rdy = 1'b0;
        check("lat_count", count, 1);
        check("lat_val_next", out_val, 1);
        check("lat_msg_next", out_msg, 16'hABCD);
        out_rdy = 1'b1;
        tick();
        check("lat_drain_count", count, 0);
`endif
        out_rdy = 1'b0;

        // ---------------- streaming at count 2 ----------------
        in_val = 1'b1; in_msg = 16'h0010; q.push_back(16'h0010);
        tick();
        in_msg = 16'h0011; q.push_back(16'h0011);
        tick();
        check("stream_pre_count", count, 2);
        out_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_msg = 16'h0100 + 16'(k);
            #1;
            exp_msg = q.pop_front();
            check("stream_msg", out_msg, exp_msg);
            q.push_back(in_msg);
            tick();
            check("stream_count", count, 2);
        end

        // ---------------- flush at count 3 ----------------
        out_rdy = 1'b0; in_msg = 16'h0200;
        tick();
        check("preflush_count", count, 3);
        flush = 1'b1; in_msg = 16'hBEEF; out_rdy = 1'b1;
        tick();
        flush = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
        check("flush_count", count, 0);
        check("flush_out_val", out_val, 0);
        check("flush_out_msg", out_msg, 0);
        check("flush_in_rdy", in_rdy, 1);
        q.delete();

        // after flush, new head is the next enqueue (BEEF dropped)
        in_val = 1'b1; in_msg = 16'h2222;
        tick();
        check("postflush_msg", out_msg, 16'h2222);
        // simultaneous enq/deq at count 1
        in_msg = 16'h3333; out_rdy = 1'b1;
        tick();
        check("c1_both_count", count, 1);
        check("c1_both_msg", out_msg, 16'h3333);
        out_rdy = 1'b0; in_msg = 16'h4444;
        tick();
        in_val = 1'b0;
        check("prerst_count", count, 2);

        // ---------------- async reset mid-cycle ----------------
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_out_val", out_val, 0);
        check("arst_out_msg", out_msg, 0);
        check("arst_in_rdy", in_rdy, 1);
        check("arst_aempty", almost_empty, 1);
        check("arst_afull", almost_full, 0);
        #1;
        rst = 1'b0;
        tick();
        check("postrst_out_val", out_val, 0);
        check("postrst_out_msg", out_msg, 0);

        // ---------------- DEPTH=3 wrap ----------------
        for (int k = 0; k < 10; k++) begin
            in_val3 = 1'b1; in_msg3 = 16'h0300 + 16'(k); out_rdy3 = 1'b0;
            tick();
            in_val3 = 1'b0;
            check("d3_enq_count", count3, 1);
            out_rdy3 = 1'b1;
            #1;
            check("d3_msg", out_msg3, 16'h0300 + 16'(k));
            tick();
            out_rdy3 = 1'b0;
            check("d3_deq_count", count3, 0);
        end
        for (int k = 0; k < 3; k++) begin
            in_val3 = 1'b1; in_msg3 = 16'h0400 + 16'(k);
            tick();
        end
        in_val3 = 1'b0;
        check("d3_full_count", count3, 3);
        check("d3_full_in_rdy", in_rdy3, 0);
        check("d3_full_head", out_msg3, 16'h0400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
